// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment helper for the data-memory
// access controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int ADDR_LIMIT_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Halves need an even byte address, words need a 4-byte-aligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory
// word, and merges store data into the addressed lanes of an old word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  bit_pos;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign bit_pos = {offset, 3'b000};

  always_comb begin
    sel_byte  = rd_word[bit_pos +: 8];
    sel_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // Little-endian lanes: only the addressed byte/half is replaced.
  always_comb begin
    merged_word = rd_word;
    case (size)
      SZ_BYTE: merged_word[bit_pos +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) merged_word[31:16] = wdata[15:0];
        else           merged_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged_word = wdata;
      default: merged_word = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller between the MEM stage and the banked data memory:
// word conversion, load extension, read-modify-write for sub-word stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_RD_LAT = 2,
  parameter int WORD_BITS  = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataIn,
  output logic        mem_readWrite,
  input  logic [31:0] mem_dataOut
);

  localparam int CW = $clog2(MEM_RD_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_RD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic capture_rd;

  logic                 wr_q;
  logic [1:0]           size_q;
  logic                 sgn_q;
  logic [WORD_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic                 err_q;
  logic [31:0]          word_q;

  logic        accept;
  logic        req_err;
  logic [31:0] word_index;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_ready  = (state == ST_IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign word_index = {{(32-WORD_BITS){1'b0}}, addr_q[WORD_BITS+1:2]};

  assign req_err = (req_size == 2'b11)
                || is_misaligned(req_size, req_addr[1:0])
                || (req_addr[31:ADDR_LIMIT_BIT] != '0);

  dmem_lane_align u_lane_align (
    .rd_word     (word_q),
    .size        (size_q),
    .is_signed   (sgn_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Word stores skip the read; everything else that is legal reads first.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    capture_rd    = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    mem_addr      = '0;
    mem_dataIn    = '0;
    mem_readWrite = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nx = '0;
          if (req_err) begin
            state_nx = ST_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_nx = ST_WRITE;
          end else begin
            state_nx = ST_RD_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      ST_RD_WAIT: begin
        mem_addr = word_index;
        if (cnt == '0) begin
          capture_rd = 1'b1;
          cnt_nx     = '0;
          state_nx   = wr_q ? ST_WRITE : ST_RESP;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      ST_WRITE: begin
        mem_addr      = word_index;
        mem_readWrite = 1'b1;
        mem_dataIn    = merged_word;
        cnt_nx        = '0;
        state_nx      = ST_RESP;
      end
      ST_RESP: begin
        mem_addr  = word_index;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (wr_q || err_q) ? 32'h0 : load_data;
        cnt_nx    = '0;
        state_nx  = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Request fields are frozen at accept; the read word is held for merge/extend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr[WORD_BITS+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
        word_q  <= '0;
      end else if (capture_rd) begin
        word_q <= mem_dataOut;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table of requests with constant
// expectations, scoreboard queue popped on each response, plus corner sequences.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataIn;
  logic        mem_readWrite;
  logic [31:0] mem_dataOut;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nw;
    logic [31:0] waddr;
    logic [31:0] wword;
    int          wlat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_word;
    exp_t        ex;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  exp_t sbq[$];
  int   acc_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int nw_cur   = 0;
  int wl_cur   = 0;
  int write_total = 0;
  int rsp_total   = 0;
  logic [31:0] wa_cur = '0;
  logic [31:0] ww_cur = '0;

  logic [31:0] mem [0:8191];
  logic        preload_en;
  logic [12:0] preload_idx;
  logic [31:0] preload_data;

  dmem_access_ctrl #(.MEM_RD_LAT(2), .WORD_BITS(13)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_addr      (mem_addr),
    .mem_dataIn    (mem_dataIn),
    .mem_readWrite (mem_readWrite),
    .mem_dataOut   (mem_dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: combinational read, posedge write, backdoor preload port.
  assign mem_dataOut = mem[mem_addr[12:0]];

  always @(posedge clk) begin
    if (mem_readWrite)   mem[mem_addr[12:0]] <= mem_dataIn;
    else if (preload_en) mem[preload_idx]    <= preload_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic pre, input logic [31:0] pw,
                               input logic [31:0] rd, input logic er, input int lat,
                               input int nw, input logic [31:0] wa, input logic [31:0] ww,
                               input int wl);
    vec_t v;
    v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.pre = pre; v.pre_word = pw;
    v.ex.rdata = rd; v.ex.err = er; v.ex.lat = lat; v.ex.nw = nw;
    v.ex.waddr = wa; v.ex.wword = ww; v.ex.wlat = wl;
    return v;
  endfunction

  // Monitor: tracks accepts and writes, pops the scoreboard on each response.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (req_valid && req_ready) begin
      acc_cyc = cyc;
      nw_cur  = 0;
      acc_log.push_back(cyc);
    end
    if (mem_readWrite) begin
      nw_cur++;
      write_total++;
      wa_cur = mem_addr;
      ww_cur = mem_dataIn;
      wl_cur = cyc - acc_cyc;
    end else begin
      checkOutput("dataIn_idle", mem_dataIn, 32'h0);
    end
    if (rsp_valid) begin
      rsp_total++;
      if (sbq.size() == 0) begin
        checkOutput("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        e = sbq.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        checkOutput("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        checkOutput("write_count", 32'(nw_cur), 32'(e.nw));
        if (e.nw > 0) begin
          checkOutput("write_addr", wa_cur, e.waddr);
          checkOutput("write_data", ww_cur, e.wword);
          checkOutput("write_cycle", 32'(wl_cur), 32'(e.wlat));
        end
      end
    end
  end

  task automatic preload(input logic [12:0] idx, input logic [31:0] d);
    @(posedge clk);
    #1;
    preload_en   = 1'b1;
    preload_idx  = idx;
    preload_data = d;
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sbq.push_back(v.ex);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_timeout", 32'(sbq.size()), 32'h0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0;
    int r0;
    vec_t v;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    preload_en = 1'b0; preload_idx = '0; preload_data = '0;

    //          wr    size     sgn   addr          wdata         pre   pre_word      rdata         err  lat nw waddr    wword         wl
    vecs[0]  = mkv(1'b0, SZ_BYTE, 1'b1, 32'h0000_1003, 32'h0,        1'b1, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[1]  = mkv(1'b1, SZ_BYTE, 1'b0, 32'h0000_0402, 32'h0000_00AB, 1'b1, 32'h1122_3344, 32'h0,        1'b0, 4, 1, 32'h100, 32'h11AB_3344, 3);
    vecs[2]  = mkv(1'b1, SZ_WORD, 1'b0, 32'h0000_7FFC, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0,        1'b0, 2, 1, 32'h1FFF, 32'hDEAD_BEEF, 1);
    vecs[3]  = mkv(1'b0, SZ_WORD, 1'b0, 32'h0000_7FFC, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[4]  = mkv(1'b0, SZ_HALF, 1'b1, 32'h0000_0001, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,   32'h0,        0);
    vecs[5]  = mkv(1'b0, SZ_WORD, 1'b0, 32'h0000_8000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,   32'h0,        0);
    vecs[6]  = mkv(1'b0, SZ_HALF, 1'b0, 32'h0000_0002, 32'h0,        1'b1, 32'h9234_5678, 32'h0000_9234, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[7]  = mkv(1'b0, SZ_HALF, 1'b1, 32'h0000_0002, 32'h0,        1'b0, 32'h0,        32'hFFFF_9234, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[8]  = mkv(1'b0, SZ_BYTE, 1'b0, 32'h0000_0003, 32'h0,        1'b0, 32'h0,        32'h0000_0092, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[9]  = mkv(1'b1, SZ_HALF, 1'b0, 32'h0000_0006, 32'h0000_CAFE, 1'b1, 32'h5566_7788, 32'h0,        1'b0, 4, 1, 32'h1,   32'hCAFE_7788, 3);
    vecs[10] = mkv(1'b1, SZ_HALF, 1'b0, 32'h0000_0004, 32'h1234_BEEF, 1'b1, 32'h5566_7788, 32'h0,        1'b0, 4, 1, 32'h1,   32'h5566_BEEF, 3);
    vecs[11] = mkv(1'b0, 2'b11,   1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,   32'h0,        0);
    vecs[12] = mkv(1'b1, SZ_WORD, 1'b0, 32'h0000_0001, 32'h1234_5678, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,   32'h0,        0);
    vecs[13] = mkv(1'b0, SZ_BYTE, 1'b0, 32'h0001_0000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,   32'h0,        0);
    vecs[14] = mkv(1'b0, SZ_WORD, 1'b1, 32'h0000_0008, 32'h0,        1'b1, 32'h8000_0001, 32'h8000_0001, 1'b0, 3, 0, 32'h0,   32'h0,        0);
    vecs[15] = mkv(1'b1, SZ_BYTE, 1'b0, 32'h0000_0001, 32'hFFFF_FF5A, 1'b1, 32'hAABB_CCDD, 32'h0,        1'b0, 4, 1, 32'h0,   32'hAABB_5ADD, 3);
    vecs[16] = mkv(1'b0, SZ_BYTE, 1'b1, 32'h0000_0009, 32'h0,        1'b1, 32'h0000_7F00, 32'h0000_007F, 1'b0, 3, 0, 32'h0,   32'h0,        0);

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_rw", {31'b0, mem_readWrite}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) preload(vecs[i].addr[14:2], vecs[i].pre_word);
      applyStimulus(vecs[i]);
      waitDone();
    end

    // req_valid held high across two loads: second accept only after RESP.
    preload(13'h0, 32'h9234_5678);
    acc_log.delete();
    v = mkv(1'b0, SZ_HALF, 1'b0, 32'h0000_0002, 32'h0, 1'b0, 32'h0, 32'h0000_9234, 1'b0, 3, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    sbq.push_back(v.ex);
    sbq.push_back(v.ex);
    for (int k = 0; k < 20 && acc_log.size() < 2; k++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("b2b_accepts", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2)
      checkOutput("b2b_spacing", 32'(acc_log[1] - acc_log[0]), 32'd4);
    waitDone();

    // Reset asserted while a sub-word store waits on its read.
    preload(13'h100, 32'h1122_3344);
    w0 = write_total;
    r0 = rsp_total;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h0000_0402; req_wdata = 32'h0000_00AB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("mid_rst_mem_addr", mem_addr, 32'h0);
    checkOutput("mid_rst_rw", {31'b0, mem_readWrite}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'b0, req_ready}, 32'h1);
    repeat (6) @(negedge clk);
    checkOutput("post_rst_no_write", 32'(write_total - w0), 32'h0);
    checkOutput("post_rst_no_rsp", 32'(rsp_total - r0), 32'h0);
    checkOutput("post_rst_mem_word", mem[13'h100], 32'h1122_3344);

    applyStimulus(mkv(1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0,
                      32'h1122_3344, 1'b0, 3, 0, 32'h0, 32'h0, 0));
    waitDone();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
